// File: rtl/txsrc_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tag_txsrc_pkg
//  Description : Shared definitions for the transmit bit-source scheduler:
//                source codes, scheduler state encoding, default sizes and a
//                source-code to one-hot helper.
//  Revision    : 1.0  initial release
// ============================================================================
package tag_txsrc_pkg;

    // Default plan geometry: four segments, 8-bit segment lengths
    localparam int NSEG_DEFAULT = 4;
    localparam int LENW_DEFAULT = 8;

    // Transmit bit source codes
    localparam logic [1:0] BITSRC_RNG  = 2'd0;
    localparam logic [1:0] BITSRC_EPC  = 2'd1;
    localparam logic [1:0] BITSRC_READ = 2'd2;
    localparam logic [1:0] BITSRC_UID  = 2'd3;

    // Scheduler state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot strobe lane for a given source code
    function automatic logic [3:0] src_onehot(input logic [1:0] code);
        logic [3:0] v;
        v = 4'b0000;
        case (code)
            BITSRC_RNG:  v = 4'b0001;
            BITSRC_EPC:  v = 4'b0010;
            BITSRC_READ: v = 4'b0100;
            BITSRC_UID:  v = 4'b1000;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/txsrc_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : txsrc_sched_if
//  Description : Bundle between the controller / bit sources / sequencer and
//                the transmit source scheduler.
//                master : drives plan, start/abort, strobe, source bits/done
//                slave  : the scheduler; drives src_clk, tx_bit, tx_done,
//                         sel, seg_idx, busy
//  Revision    : 1.0  initial release
// ============================================================================
interface txsrc_sched_if #(
    parameter int NSEG = tag_txsrc_pkg::NSEG_DEFAULT,
    parameter int LENW = tag_txsrc_pkg::LENW_DEFAULT
) ();

    logic                   start;
    logic                   abort;
    logic [2*NSEG-1:0]      seg_src;
    logic [LENW*NSEG-1:0]   seg_len;
    logic [1:0]             seg_last;
    logic                   tx_bit_stb;
    logic [3:0]             src_bit;
    logic [3:0]             src_done;
    logic [3:0]             src_clk;
    logic                   tx_bit;
    logic                   tx_done;
    logic [1:0]             sel;
    logic [1:0]             seg_idx;
    logic                   busy;

    modport master (
        output start, abort, seg_src, seg_len, seg_last, tx_bit_stb,
               src_bit, src_done,
        input  src_clk, tx_bit, tx_done, sel, seg_idx, busy
    );

    modport slave (
        input  start, abort, seg_src, seg_len, seg_last, tx_bit_stb,
               src_bit, src_done,
        output src_clk, tx_bit, tx_done, sel, seg_idx, busy
    );

endinterface
`default_nettype wire

// File: rtl/txsrc_sched_bitcounter.sv
`default_nettype none
// ============================================================================
//  Module      : seg_bitcounter
//  Description : Per-segment bit counter with synchronous clear, increment and
//                terminal-count detect. o_tc is high on the increment that
//                brings the count equal to i_len.
//  Ports       : clk, reset (async, active-high)
//                i_clr  - clear to zero (wins over i_inc)
//                i_inc  - count one forwarded bit
//                i_len  - segment length to compare against
//                o_tc   - this increment completes the segment
//  Revision    : 1.0  initial release
// ============================================================================
module seg_bitcounter
    import tag_txsrc_pkg::*;
#(
    parameter int LENW = LENW_DEFAULT
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            i_clr,
    input  wire logic            i_inc,
    input  wire logic [LENW-1:0] i_len,
    output logic                 o_tc
);

    logic [LENW-1:0] r_count;
    logic [LENW-1:0] w_count_inc;

    assign w_count_inc = r_count + {{(LENW-1){1'b0}}, 1'b1};

    // Compare the post-increment value so the ending strobe is flagged in
    // the same cycle it is forwarded.
    assign o_tc = i_inc && (w_count_inc == i_len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= w_count_inc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/txsrc_sched.sv
`default_nettype none
// ============================================================================
//  Module      : txsrc_sched
//  Description : Plays up to four transmit segments (each from RNG, EPC, READ
//                or UID) back-to-back into the sequencer. Segments are either
//                counted (fixed bit length) or open (run until the source
//                reports done).
//  Ports       : clk   - system clock
//                reset - asynchronous active-high reset
//                bus   - txsrc_sched_if.slave: plan, start/abort, sequencer
//                        strobe, source bits/done in; source strobes, tx_bit,
//                        tx_done, sel, seg_idx, busy out
//  Revision    : 1.0  initial release
// ============================================================================
module txsrc_sched
    import tag_txsrc_pkg::*;
#(
    parameter int NSEG = NSEG_DEFAULT,
    parameter int LENW = LENW_DEFAULT
) (
    input  wire logic    clk,
    input  wire logic    reset,
    txsrc_sched_if.slave bus
);

    state_t                 r_state;
    logic [2*NSEG-1:0]      r_seg_src;
    logic [LENW*NSEG-1:0]   r_seg_len;
    logic [1:0]             r_seg_last;
    logic [1:0]             r_seg_idx;
    logic [1:0]             r_sel;
    logic                   r_busy;
    logic                   r_tx_done;
    logic                   r_pending;

    logic [1:0]             w_src_arr [NSEG];
    logic [LENW-1:0]        w_len_arr [NSEG];
    logic [LENW-1:0]        w_cur_len;
    logic [1:0]             w_idx_nxt;
    logic                   w_run;
    logic                   w_open;
    logic                   w_open_end;
    logic                   w_req;
    logic                   w_fwd;
    logic                   w_cnt_inc;
    logic                   w_tc;
    logic                   w_seg_end;
    logic                   w_accept;
    logic                   w_cnt_clr;

    // Unpack the latched plan into per-segment fields
    for (genvar k = 0; k < NSEG; k++) begin : g_unpack
        assign w_src_arr[k] = r_seg_src[2*k +: 2];
        assign w_len_arr[k] = r_seg_len[LENW*k +: LENW];
    end

    assign w_cur_len = w_len_arr[r_seg_idx];
    assign w_idx_nxt = r_seg_idx + 2'd1;
    assign w_run     = (r_state == RUN);
    assign w_open    = (w_cur_len == '0);

    // An open segment ends on the first cycle its source reports done; any
    // strobe arriving in that cycle is withheld and replayed next cycle.
    assign w_open_end = w_run && w_open && bus.src_done[r_sel];
    assign w_req      = bus.tx_bit_stb | r_pending;
    assign w_fwd      = w_run && w_req && !w_open_end;
    assign w_cnt_inc  = w_fwd && !w_open;
    assign w_seg_end  = w_open_end || (w_cnt_inc && w_tc);

    // start is only honoured outside RUN, and never together with abort
    assign w_accept  = bus.start && !bus.abort && (r_state != RUN);
    assign w_cnt_clr = bus.abort || w_accept || w_seg_end;

    seg_bitcounter #(
        .LENW (LENW)
    ) u_bitcnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_cnt_clr),
        .i_inc (w_cnt_inc),
        .i_len (w_cur_len),
        .o_tc  (w_tc)
    );

    assign bus.src_clk = w_fwd ? src_onehot(r_sel) : 4'b0000;
    assign bus.tx_bit  = w_run & bus.src_bit[r_sel];
    assign bus.tx_done = r_tx_done;
    assign bus.sel     = r_sel;
    assign bus.seg_idx = r_seg_idx;
    assign bus.busy    = r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_seg_src  <= '0;
            r_seg_len  <= '0;
            r_seg_last <= 2'd0;
            r_seg_idx  <= 2'd0;
            r_sel      <= BITSRC_RNG;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
            r_pending  <= 1'b0;
        end else if (bus.abort) begin
            r_state   <= IDLE;
            r_seg_idx <= 2'd0;
            r_sel     <= BITSRC_RNG;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_seg_src  <= bus.seg_src;
                        r_seg_len  <= bus.seg_len;
                        r_seg_last <= bus.seg_last;
                        r_seg_idx  <= 2'd0;
                        r_sel      <= bus.seg_src[1:0];
                        r_busy     <= 1'b1;
                        r_tx_done  <= 1'b0;
                        r_pending  <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    if (w_seg_end) begin
                        if (r_seg_idx == r_seg_last) begin
                            // Final segment: a withheld strobe has nowhere to go
                            r_state   <= DONE;
                            r_tx_done <= 1'b1;
                            r_pending <= 1'b0;
                        end else begin
                            r_seg_idx <= w_idx_nxt;
                            r_sel     <= w_src_arr[w_idx_nxt];
                            r_pending <= w_open_end && w_req;
                        end
                    end else begin
                        // Any pending strobe was forwarded this cycle
                        r_pending <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_txsrc_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_txsrc_sched
//  Description : Self-checking bench for txsrc_sched. A table of segment plans
//                is replayed against simple bit-source models; hand-written
//                sequences cover pending replay, abort, start in RUN/DONE and
//                asynchronous reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_txsrc_sched;

    logic clk;
    logic reset;

    txsrc_sched_if #(.NSEG(4), .LENW(8)) bus ();

    txsrc_sched #(.NSEG(4), .LENW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- bit-source models ----------------
    int         cnt [4];
    int         thr [4];
    logic       src_clr;
    logic [3:0] force_done;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (src_clr)              cnt[k] <= 0;
            else if (bus.src_clk[k])  cnt[k] <= cnt[k] + 1;
        end
    end

    always_comb begin
        bus.src_bit  = 4'b0000;
        bus.src_done = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            bus.src_bit[k]  = cnt[k][1] ^ (k % 2 == 1);
            bus.src_done[k] = (cnt[k] >= thr[k]) | force_done[k];
        end
    end

    // ---------------- plan table ----------------
    typedef struct packed {
        logic [7:0]       src;
        logic [31:0]      len;
        logic [1:0]       last;
        logic [3:0][8:0]  thr;
        logic [3:0][8:0]  exp_cnt;
        logic [3:0][1:0]  exp_sel;
    } scen_t;

    scen_t tbl [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic clear_src();
        src_clr = 1'b1;
        @(posedge clk);
        #1 src_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
    endtask

    // One clock with the given strobe level; returns at the negedge
    task automatic cyc_stb(input logic s);
        @(posedge clk);
        #1 bus.tx_bit_stb = s;
        @(negedge clk);
    endtask

    task automatic run_plan(input scen_t s, input string tag);
        int   tally [4];
        int   rec [4];
        int   nrec, last_fwd, done_cyc, onehot_err, bit_err, k;
        logic phase;
        for (int j = 0; j < 4; j++) begin
            thr[j]   = int'(s.thr[j]);
            tally[j] = 0;
            rec[j]   = 0;
        end
        force_done = 4'b0000;
        clear_src();
        bus.seg_src  = s.src;
        bus.seg_len  = s.len;
        bus.seg_last = s.last;
        pulse_start();
        @(negedge clk);
        chk({tag, "_busy"}, int'(bus.busy), 1);
        chk({tag, "_sel0"}, int'(bus.sel), int'(s.exp_sel[0]));
        chk({tag, "_done_low"}, int'(bus.tx_done), 0);
        nrec = 0; last_fwd = -1; done_cyc = -1; onehot_err = 0; bit_err = 0;
        phase = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1 bus.tx_bit_stb = phase;
            phase = ~phase;
            @(negedge clk);
            if (bus.tx_done) begin
                done_cyc = c;
                break;
            end
            if (bus.src_clk != 4'b0000) begin
                if ($countones(bus.src_clk) != 1) begin
                    onehot_err++;
                end else begin
                    k = 0;
                    for (int j = 0; j < 4; j++) if (bus.src_clk[j]) k = j;
                    tally[k]++;
                    if (bus.tx_bit != bus.src_bit[k]) bit_err++;
                    if (nrec == 0 || rec[(nrec > 4 ? 4 : nrec) - 1] != k) begin
                        if (nrec < 4) rec[nrec] = k;
                        nrec++;
                    end
                end
                last_fwd = c;
            end
        end
        bus.tx_bit_stb = 1'b0;
        chk({tag, "_done_seen"}, int'(done_cyc >= 0), 1);
        chk({tag, "_done_latency"}, done_cyc - last_fwd, 1);
        for (int j = 0; j < 4; j++)
            chk($sformatf("%s_count_src%0d", tag, j), tally[j], int'(s.exp_cnt[j]));
        chk({tag, "_nseg"}, nrec, int'(s.last) + 1);
        for (int j = 0; j <= int'(s.last); j++)
            chk($sformatf("%s_sel_seg%0d", tag, j), rec[j], int'(s.exp_sel[j]));
        chk({tag, "_onehot"}, onehot_err, 0);
        chk({tag, "_txbit"}, bit_err, 0);
    endtask

    initial begin
        // RNG len 16, single segment
        tbl[0] = '{src: 8'h00, len: 32'h0000_0010, last: 2'd0,
                   thr: {9'd511, 9'd511, 9'd511, 9'd511},
                   exp_cnt: {9'd0, 9'd0, 9'd0, 9'd16},
                   exp_sel: {2'd0, 2'd0, 2'd0, 2'd0}};
        // RNG 16, READ open (done after 40), RNG 16
        tbl[1] = '{src: 8'h08, len: 32'h0010_0010, last: 2'd2,
                   thr: {9'd511, 9'd40, 9'd511, 9'd511},
                   exp_cnt: {9'd0, 9'd40, 9'd0, 9'd32},
                   exp_sel: {2'd0, 2'd0, 2'd2, 2'd0}};
        // EPC len 255 (maximum counted length)
        tbl[2] = '{src: 8'h01, len: 32'h0000_00FF, last: 2'd0,
                   thr: {9'd511, 9'd511, 9'd511, 9'd511},
                   exp_cnt: {9'd0, 9'd0, 9'd255, 9'd0},
                   exp_sel: {2'd0, 2'd0, 2'd0, 2'd1}};
        // UID 5 with UID done after 2 (ignored), then EPC 3
        tbl[3] = '{src: 8'h07, len: 32'h0000_0305, last: 2'd1,
                   thr: {9'd2, 9'd511, 9'd511, 9'd511},
                   exp_cnt: {9'd5, 9'd0, 9'd3, 9'd0},
                   exp_sel: {2'd0, 2'd0, 2'd1, 2'd3}};
        // EPC 1, RNG open (done after 3), READ 2, UID 4
        tbl[4] = '{src: 8'hE1, len: 32'h0402_0001, last: 2'd3,
                   thr: {9'd511, 9'd511, 9'd511, 9'd3},
                   exp_cnt: {9'd4, 9'd2, 9'd1, 9'd3},
                   exp_sel: {2'd3, 2'd2, 2'd0, 2'd1}};
        // UID len 3 (used for restart from DONE)
        tbl[5] = '{src: 8'h03, len: 32'h0000_0003, last: 2'd0,
                   thr: {9'd511, 9'd511, 9'd511, 9'd511},
                   exp_cnt: {9'd3, 9'd0, 9'd0, 9'd0},
                   exp_sel: {2'd0, 2'd0, 2'd0, 2'd3}};

        for (int j = 0; j < 4; j++) thr[j] = 511;
        force_done     = 4'b0000;
        src_clr        = 1'b1;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.seg_src    = '0;
        bus.seg_len    = '0;
        bus.seg_last   = 2'd0;
        bus.tx_bit_stb = 1'b1;

        // Reset state (strobe held high: must not reach any source)
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_tx_done", int'(bus.tx_done), 0);
        chk("rst_sel", int'(bus.sel), 0);
        chk("rst_seg_idx", int'(bus.seg_idx), 0);
        chk("rst_src_clk", int'(bus.src_clk), 0);
        chk("rst_tx_bit", int'(bus.tx_bit), 0);
        @(posedge clk);
        #1 reset = 1'b0; bus.tx_bit_stb = 1'b0; src_clr = 1'b0;

        // Strobe in IDLE is ignored
        cyc_stb(1'b1);
        chk("idle_src_clk", int'(bus.src_clk), 0);
        cyc_stb(1'b0);

        for (int i = 0; i < 5; i++) run_plan(tbl[i], $sformatf("tbl%0d", i));

        // Open READ segment ends on the same cycle as a strobe -> replay to RNG
        for (int j = 0; j < 4; j++) thr[j] = 511;
        clear_src();
        bus.seg_src = 8'h02; bus.seg_len = 32'h0000_0200; bus.seg_last = 2'd1;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            cyc_stb(1'b1);
            chk("pend_read_bit", int'(bus.src_clk), 4);
            cyc_stb(1'b0);
        end
        @(posedge clk);
        #1 bus.tx_bit_stb = 1'b1; force_done[2] = 1'b1;
        @(negedge clk);
        chk("pend_withheld", int'(bus.src_clk), 0);
        @(posedge clk);
        #1 bus.tx_bit_stb = 1'b0; force_done = 4'b0000;
        @(negedge clk);
        chk("pend_replay", int'(bus.src_clk), 1);
        chk("pend_sel", int'(bus.sel), 0);
        chk("pend_seg_idx", int'(bus.seg_idx), 1);
        cyc_stb(1'b1);
        chk("pend_next_bit", int'(bus.src_clk), 1);
        cyc_stb(1'b0);
        chk("pend_tx_done", int'(bus.tx_done), 1);
        chk("pend_read_cnt", cnt[2], 3);
        chk("pend_rng_cnt", cnt[0], 2);

        // Abort during segment 1 of 3
        clear_src();
        bus.seg_src = 8'h34; bus.seg_len = 32'h0010_1010; bus.seg_last = 2'd2;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            cyc_stb(1'b1);
            cyc_stb(1'b0);
        end
        chk("abort_pre_idx", int'(bus.seg_idx), 1);
        pulse_abort();
        @(negedge clk);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_seg_idx", int'(bus.seg_idx), 0);
        chk("abort_sel", int'(bus.sel), 0);
        chk("abort_tx_done", int'(bus.tx_done), 0);
        cyc_stb(1'b1);
        chk("abort_no_src_clk", int'(bus.src_clk), 0);
        cyc_stb(1'b0);
        run_plan(tbl[0], "after_abort");

        // start while in RUN is ignored; start in DONE restarts
        clear_src();
        bus.seg_src = 8'h00; bus.seg_len = 32'h0000_0004; bus.seg_last = 2'd0;
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            cyc_stb(1'b1);
            cyc_stb(1'b0);
        end
        bus.seg_src = 8'hFF; bus.seg_len = 32'h0808_0808; bus.seg_last = 2'd3;
        pulse_start();
        @(negedge clk);
        chk("run_start_sel", int'(bus.sel), 0);
        chk("run_start_idx", int'(bus.seg_idx), 0);
        for (int i = 0; i < 2; i++) begin
            cyc_stb(1'b1);
            cyc_stb(1'b0);
        end
        chk("run_start_done", int'(bus.tx_done), 1);
        chk("run_start_rng", cnt[0], 4);
        chk("run_start_uid", cnt[3], 0);
        run_plan(tbl[5], "done_restart");

        // Asynchronous reset mid-RUN
        clear_src();
        bus.seg_src = 8'h01; bus.seg_len = 32'h0000_000A; bus.seg_last = 2'd0;
        pulse_start();
        cyc_stb(1'b1);
        cyc_stb(1'b0);
        @(posedge clk);
        #1 bus.tx_bit_stb = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("areset_busy", int'(bus.busy), 0);
        chk("areset_sel", int'(bus.sel), 0);
        chk("areset_seg_idx", int'(bus.seg_idx), 0);
        chk("areset_tx_done", int'(bus.tx_done), 0);
        chk("areset_src_clk", int'(bus.src_clk), 0);
        chk("areset_tx_bit", int'(bus.tx_bit), 0);
        bus.tx_bit_stb = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
